// File: rtl/root_nonrestoring_core_pkg.sv
// rtl/root_nonrestoring_core_pkg.sv - shared types and remainder correction for the square-root core
package root_nonrestoring_core_pkg;

  typedef logic [31:0] rad_t;
  typedef logic [15:0] root_t;
  typedef logic [16:0] rem_out_t;
  typedef logic [3:0]  iter_t;

  // A negative internal remainder is one step behind; adding 2q+1 restores it.
  function automatic rem_out_t correct_rem(input logic signed [17:0] rem, input root_t root);
    logic signed [17:0] sum;
    sum = rem + $signed({1'b0, root, 1'b1});
    return rem[17] ? sum[16:0] : rem[16:0];
  endfunction

endpackage

// File: rtl/root_nonrestoring_core.sv
// rtl/root_nonrestoring_core.sv - iterative non-restoring 32-bit integer square root, two bits per clock
module root_nonrestoring_core
  import root_nonrestoring_core_pkg::*;
(
  input  logic     clk,
  input  logic     clrn,
  input  rad_t     d,
  input  logic     load,
  output root_t    q,
  output rem_out_t r,
  output logic     busy,
  output logic     ready,
  output iter_t    count
);

  localparam int ITER = 16;
  localparam int RW   = 18;

  rad_t                 rad;
  logic signed [RW-1:0] rem;
  logic signed [RW-1:0] rem_shift;
  logic signed [RW-1:0] rem_next;
  logic                 busy_d;

  always_comb begin
    rem_shift = {rem[RW-3:0], rad[31:30]};
    if (!rem[RW-1])
      rem_next = rem_shift - {q, 2'b01};
    else
      rem_next = rem_shift + {q, 2'b11};
  end

  assign r     = correct_rem(rem, q);
  assign ready = ~busy & busy_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rad    <= '0;
      rem    <= '0;
      q      <= '0;
      count  <= '0;
      busy   <= 1'b0;
      busy_d <= 1'b0;
    end else begin
      busy_d <= busy;
      // Load wins in every state, so a load while busy simply restarts.
      if (load) begin
        rad   <= d;
        rem   <= '0;
        q     <= '0;
        count <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        rad   <= rad << 2;
        rem   <= rem_next;
        q     <= {q[14:0], ~rem_next[RW-1]};
        count <= count + 4'd1;
        if (count == 4'(ITER - 1))
          busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_root_nonrestoring_core.sv
// tb/tb_root_nonrestoring_core.sv - self-checking bench for root_nonrestoring_core
module tb_root_nonrestoring_core;

  logic        clk;
  logic        clrn;
  logic [31:0] d;
  logic        load;
  logic [15:0] q;
  logic [16:0] r;
  logic        busy;
  logic        ready;
  logic [3:0]  count;

  int checks;
  int failures;

  root_nonrestoring_core dut (
    .clk   (clk),
    .clrn  (clrn),
    .d     (d),
    .load  (load),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .ready (ready),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic pulse_load(input logic [31:0] val);
    @(negedge clk);
    d    = val;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // One complete operation; full=1 also checks per-cycle busy/count/ready timing.
  task automatic run_op(input string tag, input logic [31:0] val, input logic [15:0] eq,
                        input logic [16:0] er, input bit full);
    pulse_load(val);
    if (full) begin
      check({tag, "_busy_e0"}, 64'(busy), 64'd1);
      check({tag, "_count_e0"}, 64'(count), 64'd0);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (full && k < 16 && (k == 1 || k == 8 || k == 15)) begin
        check({tag, "_busy_mid"}, 64'(busy), 64'd1);
        check({tag, "_count_mid"}, 64'(count), 64'(k));
        check({tag, "_ready_mid"}, 64'(ready), 64'd0);
      end
    end
    check({tag, "_q"}, 64'(q), 64'(eq));
    check({tag, "_r"}, 64'(r), 64'(er));
    if (full) begin
      check({tag, "_busy_e16"}, 64'(busy), 64'd0);
      check({tag, "_ready_e16"}, 64'(ready), 64'd1);
      check({tag, "_count_e16"}, 64'(count), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_ready_after"}, 64'(ready), 64'd0);
      check({tag, "_q_hold"}, 64'(q), 64'(eq));
      check({tag, "_r_hold"}, 64'(r), 64'(er));
    end
  endtask

  initial begin
    int pulses;
    bit found;
    logic [31:0] v;
    longint unsigned mq;

    checks   = 0;
    failures = 0;
    clrn     = 1'b0;
    load     = 1'b0;
    d        = '0;
    #12;
    check("rst_q", 64'(q), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    run_op("c0", 32'hC000_0000, 16'hDDB3, 17'h174D7, 1'b1);
    run_op("ff", 32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE, 1'b1);
    run_op("zero", 32'd0, 16'd0, 17'd0, 1'b1);
    run_op("sixteen", 32'd16, 16'd4, 17'd0, 1'b1);
    run_op("two", 32'd2, 16'd1, 17'd1, 1'b1);

    // Restart at count=5: one ready pulse, result from the second radicand.
    pulses = 0;
    pulse_load(32'hC000_0000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
      if (count == 4'd5) found = 1'b1;
    end
    check("restart_reach5", 64'(found), 64'd1);
    pulse_load(32'd16);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_count", 64'(count), 64'd0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
      if (k == 16) begin
        check("restart_q", 64'(q), 64'd4);
        check("restart_r", 64'(r), 64'd0);
      end
    end
    check("restart_pulses", 64'(pulses), 64'd1);

    // Asynchronous reset at count=8.
    pulse_load(32'hC000_0000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (count == 4'd8) found = 1'b1;
    end
    check("arst_reach8", 64'(found), 64'd1);
    #2 clrn = 1'b0;
    #1;
    check("arst_q", 64'(q), 64'd0);
    check("arst_r", 64'(r), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(ready), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (ready || busy) pulses++;
    end
    check("arst_quiet", 64'(pulses), 64'd0);

    // Load held three cycles, then a load coinciding with E16.
    @(negedge clk);
    d = 32'd1000;
    load = 1'b1;
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
    check("held_busy", 64'(busy), 64'd1);
    check("held_count", 64'(count), 64'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    d = 32'd99;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    check("e16_busy", 64'(busy), 64'd1);
    check("e16_ready", 64'(ready), 64'd0);
    check("e16_count", 64'(count), 64'd0);
    repeat (16) @(posedge clk);
    #1;
    check("e16_q", 64'(q), 64'd9);
    check("e16_r", 64'(r), 64'd18);
    check("e16_ready_done", 64'(ready), 64'd1);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      v  = $urandom;
      if (i % 4 == 1) v = v >> $urandom_range(31, 0);
      mq = isqrt(64'(v));
      run_op("rand", v, 16'(mq), 17'(64'(v) - mq * mq), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
